// File: rtl/adder_accum_pkg.sv
// adder_accum_pkg: shared state encoding, counter sizing and parameter legality helpers.
package adder_accum_pkg;

  typedef enum logic {S_ACCUM = 1'b0, S_DONE = 1'b1} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int cnt_width(input int frame_len);
    return clog2(frame_len) > 1 ? clog2(frame_len) : 1;
  endfunction

  function automatic bit params_ok(input int data_width, input int acc_width, input int frame_len);
    return acc_width >= 3 * data_width && frame_len >= 1;
  endfunction

endpackage

// File: rtl/adder_frame_accumulator_frame_counter.sv
// frame_counter: counts accepted samples within a frame and flags the last one.
module frame_counter
  import adder_accum_pkg::*;
#(
  parameter int FRAME_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic load1,
  input  logic clr,
  output logic last
);

  localparam int CW = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  // A single-sample frame has no count 1; the first sample is already the last.
  localparam logic [CW-1:0] ONE = CW'(FRAME_LEN > 1 ? 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (load1) r_cnt <= ONE;
    else if (inc) r_cnt <= last ? '0 : r_cnt + 1'b1;

  assign last = r_cnt == LAST;

endmodule

// File: rtl/adder_frame_accumulator.sv
// adder_frame_accumulator: registers adder-array {cout,sum} words and sums FRAME_LEN of them
// into a frame total presented on a valid/ready output with a sticky overflow flag.
module adder_frame_accumulator
  import adder_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int FRAME_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] sum,
  input  logic [DATA_WIDTH-1:0]   cout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    acc,
  output logic                    ovf
);

  if (!params_ok(DATA_WIDTH, ACC_WIDTH, FRAME_LEN)) begin : g_param_check
    $error("adder_frame_accumulator: need ACC_WIDTH >= 3*DATA_WIDTH and FRAME_LEN >= 1");
  end

  state_e               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_sample;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_sample  = ACC_WIDTH'({cout, sum});
  assign in_ready  = r_state == S_ACCUM || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_release = r_state == S_DONE && out_ready;
  // On release the finished total is dropped, so a same-cycle sample starts the new frame from zero.
  assign w_base    = w_release ? '0 : r_acc;
  assign w_sum     = {1'b0, w_base} + {1'b0, w_sample};

  frame_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (w_accept && r_state == S_ACCUM),
    .load1(w_release && w_accept),
    .clr  (w_release && !w_accept),
    .last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept || w_release) begin
        r_acc <= w_accept ? w_sum[ACC_WIDTH-1:0] : '0;
        r_ovf <= w_accept && (w_sum[ACC_WIDTH] || (r_ovf && !w_release));
      end
      if (r_state == S_ACCUM && w_accept && w_last) r_state <= S_DONE;
      else if (w_release) r_state <= (w_accept && FRAME_LEN == 1) ? S_DONE : S_ACCUM;
    end

  assign out_valid = r_state == S_DONE;
  assign acc       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_frame_accumulator.sv
// tb_adder_frame_accumulator: directed frames on three configurations, frame totals checked by a scoreboard monitor.
module tb_adder_frame_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv[3];
  logic        ordy[3];
  logic        ir[3];
  logic        ov[3];
  logic        of[3];
  logic [11:0] smp[3];
  logic [15:0] acc0;
  logic [11:0] acc1;
  logic [15:0] acc2;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  adder_frame_accumulator u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .sum(smp[0][7:0]), .cout(smp[0][11:8]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .acc(acc0), .ovf(of[0])
  );

  adder_frame_accumulator #(.ACC_WIDTH(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .sum(smp[1][7:0]), .cout(smp[1][11:8]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .acc(acc1), .ovf(of[1])
  );

  adder_frame_accumulator #(.FRAME_LEN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .sum(smp[2][7:0]), .cout(smp[2][11:8]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .acc(acc2), .ovf(of[2])
  );

  function automatic logic [15:0] acc_of(input int d);
    return d == 0 ? acc0 : d == 1 ? {4'h0, acc1} : acc2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [11:0] s);
    int t;
    t = 0;
    while (!ir[d] && t < 50) begin
      step;
      t++;
    end
    if (!ir[d]) chk("in_ready timeout", 32'(ir[d]), 1);
    iv[d]  = 1'b1;
    smp[d] = s;
    step;
    iv[d]  = 1'b0;
  endtask

  task automatic release_frame(input int d);
    ordy[d] = 1'b1;
    step;
    ordy[d] = 1'b0;
  endtask

  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && ordy[d]) begin
          if ((d == 0 ? q0.size() : d == 1 ? q1.size() : q2.size()) == 0) begin
            chk("unexpected frame", 32'(d), 32'hFFFF_FFFF);
          end else begin
            e = d == 0 ? q0.pop_front() : d == 1 ? q1.pop_front() : q2.pop_front();
            chk($sformatf("frame total dut%0d", d), 32'({of[d], acc_of(d)}), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
      smp[d] = '0;
    end
    #3;
    chk("reset out_valid", 32'(ov[0]), 0);
    chk("reset acc", 32'(acc0), 0);
    chk("reset ovf", 32'(of[0]), 0);
    chk("reset in_ready", 32'(ir[0]), 1);
    #9 rst_n = 1'b1;
    step;

    q0.push_back({1'b0, 16'h1000});
    send(0, 12'h0FF); send(0, 12'h001); send(0, 12'hF00); send(0, 12'h000);
    chk("basic out_valid", 32'(ov[0]), 1);
    chk("basic acc", 32'(acc0), 32'h1000);
    chk("basic ovf", 32'(of[0]), 0);
    chk("basic in_ready held", 32'(ir[0]), 0);
    release_frame(0);
    chk("release acc", 32'(acc0), 0);
    chk("release out_valid", 32'(ov[0]), 0);
    chk("release in_ready", 32'(ir[0]), 1);

    q0.push_back({1'b0, 16'h000A});
    send(0, 12'h001); send(0, 12'h002); send(0, 12'h003); send(0, 12'h004);
    iv[0]  = 1'b1;
    smp[0] = 12'h123;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp out_valid", 32'(ov[0]), 1);
      chk("bp acc", 32'(acc0), 32'h000A);
      chk("bp in_ready", 32'(ir[0]), 0);
    end
    ordy[0] = 1'b1;
    step;
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    chk("simul out_valid", 32'(ov[0]), 0);
    chk("simul acc", 32'(acc0), 32'h123);
    q0.push_back({1'b0, 16'h0723});
    send(0, 12'h100); send(0, 12'h200);
    chk("simul cnt started at 1", 32'(ov[0]), 0);
    send(0, 12'h300);
    chk("simul frame done", 32'(ov[0]), 1);
    chk("simul frame acc", 32'(acc0), 32'h0723);
    release_frame(0);

    q0.push_back({1'b0, 16'h0004});
    send(0, 12'h005); send(0, 12'h006);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset acc", 32'(acc0), 0);
    chk("async reset out_valid", 32'(ov[0]), 0);
    chk("async reset ovf", 32'(of[0]), 0);
    #2 rst_n = 1'b1;
    step;
    send(0, 12'h001); send(0, 12'h001); send(0, 12'h001);
    chk("post reset partial", 32'(ov[0]), 0);
    send(0, 12'h001);
    chk("post reset done", 32'(ov[0]), 1);
    chk("post reset acc", 32'(acc0), 32'h0004);
    release_frame(0);

    q1.push_back({1'b1, 16'h0FFC});
    for (int i = 0; i < 4; i++) send(1, 12'hFFF);
    chk("ovf set", 32'(of[1]), 1);
    chk("ovf acc", 32'(acc1), 32'hFFC);
    release_frame(1);
    chk("ovf cleared", 32'(of[1]), 0);
    q1.push_back({1'b0, 16'h0004});
    for (int i = 0; i < 4; i++) send(1, 12'h001);
    chk("no ovf acc", 32'(acc1), 32'h004);
    release_frame(1);

    ordy[2] = 1'b1;
    q2.push_back({1'b0, 16'h0010});
    q2.push_back({1'b0, 16'h0020});
    q2.push_back({1'b0, 16'h0030});
    iv[2] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      smp[2] = 12'(i * 16);
      step;
      chk("stream out_valid", 32'(ov[2]), 1);
      chk("stream acc", 32'(acc2), 32'(i * 16));
    end
    iv[2] = 1'b0;
    step;
    chk("stream drained", 32'(ov[2]), 0);
    ordy[2] = 1'b0;
    step;

    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);
    chk("q2 empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
